reimu_life_ctrl: RTL

//  Downstream consumer of the boss bullet stage's aggregate `shot` hit flag. Tracks the player's remaining lives.

---
 rtl/reimu_life_ctrl_if.sv | 26 ++
 rtl/reimu_life_ctrl.sv | 134 +++++++++++++
 2 files changed

// File: rtl/reimu_life_ctrl_if.sv
// Player life-controller bus between the game logic and reimu_life_ctrl.
// Inputs to the controller: boss, shot, life_up, restart.
// Outputs from the controller: lives, invincible, reimu_visible, hit, game_over.
interface reimu_life_ctrl_if;
    logic       boss;
    logic       shot;
    logic       life_up;
    logic       restart;
    logic [2:0] lives;
    logic       invincible;
    logic       reimu_visible;
    logic       hit;
    logic       game_over;

    // Game-side view: drives requests, observes player status
    modport master (
        output boss, shot, life_up, restart,
        input  lives, invincible, reimu_visible, hit, game_over
    );

    // Controller view
    modport slave (
        input  boss, shot, life_up, restart,
        output lives, invincible, reimu_visible, hit, game_over
    );
endinterface

// File: rtl/reimu_life_ctrl.sv
// Player life tracker: counts lives, runs a blinking invincibility window after
// each hit, and holds game-over until restart. All outputs are registered.
// Ports:
//   clk22 - game tick clock
//   rst_n - synchronous active-low reset
//   bus   - reimu_life_ctrl_if.slave (boss/shot/life_up/restart in; status out)
module reimu_life_ctrl #(
    parameter int unsigned INIT_LIVES  = 3,
    parameter int unsigned MAX_LIVES   = 5,
    parameter int unsigned INV_TICKS   = 24,
    parameter int unsigned BLINK_TICKS = 3
) (
    input  logic               clk22,
    input  logic               rst_n,
    reimu_life_ctrl_if.slave   bus
);
    localparam int unsigned CNT_W   = (INV_TICKS > 1) ? $clog2(INV_TICKS) : 1;
    localparam int unsigned LIVES_W = 3;

    typedef enum logic [1:0] {
        ST_ALIVE = 2'd0,
        ST_INV   = 2'd1,
        ST_OVER  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [LIVES_W-1:0]   lives_q, lives_d;
    logic [CNT_W-1:0]     inv_cnt_q, inv_cnt_d;
    logic [CNT_W-1:0]     blink_cnt_q, blink_cnt_d;
    logic                 visible_q, visible_d;
    logic                 hit_q, hit_d;
    logic                 invincible_q, invincible_d;
    logic                 game_over_q, game_over_d;
    logic                 accept;
    logic [LIVES_W-1:0]   lives_inc;

    // State and output registers
    always_ff @(posedge clk22) begin
        if (!rst_n) begin
            state_q      <= ST_ALIVE;
            lives_q      <= LIVES_W'(INIT_LIVES);
            inv_cnt_q    <= '0;
            blink_cnt_q  <= '0;
            visible_q    <= 1'b1;
            hit_q        <= 1'b0;
            invincible_q <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            lives_q      <= lives_d;
            inv_cnt_q    <= inv_cnt_d;
            blink_cnt_q  <= blink_cnt_d;
            visible_q    <= visible_d;
            hit_q        <= hit_d;
            invincible_q <= invincible_d;
            game_over_q  <= game_over_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        lives_d     = lives_q;
        inv_cnt_d   = inv_cnt_q;
        blink_cnt_d = blink_cnt_q;
        visible_d   = visible_q;
        hit_d       = 1'b0;

        accept    = bus.boss & bus.shot;
        lives_inc = (lives_q >= LIVES_W'(MAX_LIVES)) ? lives_q : lives_q + LIVES_W'(1);

        case (state_q)
            ST_ALIVE: begin
                if (accept) begin
                    hit_d     = 1'b1;
                    visible_d = 1'b0;
                    // A same-tick extend cancels the life loss and keeps the player alive
                    if (bus.life_up || (lives_q > LIVES_W'(1))) begin
                        state_d     = ST_INV;
                        inv_cnt_d   = CNT_W'(INV_TICKS - 1);
                        blink_cnt_d = CNT_W'(BLINK_TICKS - 1);
                        if (!bus.life_up) begin
                            lives_d = lives_q - LIVES_W'(1);
                        end
                    end else begin
                        state_d = ST_OVER;
                        lives_d = '0;
                    end
                end else if (bus.life_up) begin
                    lives_d = lives_inc;
                end
            end
            ST_INV: begin
                if (bus.life_up) begin
                    lives_d = lives_inc;
                end
                if (inv_cnt_q == '0) begin
                    state_d   = ST_ALIVE;
                    visible_d = 1'b1;
                end else begin
                    inv_cnt_d = inv_cnt_q - CNT_W'(1);
                    // Toggle sprite each BLINK_TICKS ticks
                    if (blink_cnt_q == '0) begin
                        blink_cnt_d = CNT_W'(BLINK_TICKS - 1);
                        visible_d   = ~visible_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q - CNT_W'(1);
                    end
                end
            end
            ST_OVER: begin
                lives_d   = '0;
                visible_d = 1'b0;
                if (bus.restart) begin
                    state_d   = ST_ALIVE;
                    lives_d   = LIVES_W'(INIT_LIVES);
                    visible_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_ALIVE;
            end
        endcase

        invincible_d = (state_d == ST_INV);
        game_over_d  = (state_d == ST_OVER);
    end

    assign bus.lives         = lives_q;
    assign bus.invincible    = invincible_q;
    assign bus.reimu_visible = visible_q;
    assign bus.hit           = hit_q;
    assign bus.game_over     = game_over_q;
endmodule
